// File: rtl/exec_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_muldiv_if
// Description : Request/response bundle between the execute stage and the
//               multi-cycle RV32M multiply/divide unit.
//               master : execute stage (drives request, flush, hold)
//               slave  : exec_muldiv   (drives busy, valid, result)
//   valid_i  : operation request
//   op_i     : funct3 of the M-extension instruction
//   a_i/b_i  : rs1 / rs2 operands
//   flush_i  : pipeline squash
//   hold_i   : downstream stall, freezes a finished result
//   busy_o   : stall request to pipeline control
//   valid_o  : result valid
//   result_o : result
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            hold_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, op_i, a_i, b_i, flush_i, hold_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, flush_i, hold_i,
    output busy_o, valid_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/exec_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : exec_muldiv
// Description : Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/
//               DIV/DIVU/REM/REMU). One radix-2 step per cycle, operating
//               on operand magnitudes with a final sign correction.
//               Divide-by-zero, signed overflow and (optionally) single-
//               cycle multiplies complete without iterating.
// Ports       : clk_i  - clock, rising edge
//               rst_ni - asynchronous active-low reset
//               bus    - exec_muldiv_if.slave request/response bundle
// Parameters  : XLEN     - operand/result width (power of two, >= 8)
//               FAST_MUL - 0: iterative multiply, 1: registered array mult
// Revision    : 1.0 - initial release
// ============================================================================
module exec_muldiv #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  exec_muldiv_if.slave  bus
);

  localparam int                 c_CNT_W    = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [2:0] c_OP_MUL    = 3'd0;
  localparam logic [2:0] c_OP_MULH   = 3'd1;
  localparam logic [2:0] c_OP_MULHSU = 3'd2;
  localparam logic [2:0] c_OP_DIV    = 3'd4;
  localparam logic [2:0] c_OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] c_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_op;
  logic               r_neg;     // final result must be negated
  logic [XLEN-1:0]    r_hi;      // product high half / partial remainder
  logic [XLEN-1:0]    r_lo;      // multiplier / dividend -> quotient
  logic [XLEN-1:0]    r_b;       // multiplicand / divisor magnitude
  logic [XLEN-1:0]    r_result;

  // --------------------------------------------------------------------------
  // Acceptance-time decode
  // --------------------------------------------------------------------------
  logic            w_accept;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_res_neg;
  logic            w_div0;
  logic            w_ovf;
  logic            w_fast;
  logic            w_short;
  logic [XLEN-1:0] w_short_res;
  logic [2*XLEN-1:0] w_fast_prod;

  assign w_accept   = bus.valid_i & ~bus.flush_i;
  assign w_is_div   = bus.op_i[2];
  assign w_a_signed = (bus.op_i == c_OP_MULH) | (bus.op_i == c_OP_MULHSU) |
                      (bus.op_i == c_OP_DIV)  | (bus.op_i == c_OP_REM);
  assign w_b_signed = (bus.op_i == c_OP_MULH) | (bus.op_i == c_OP_DIV) |
                      (bus.op_i == c_OP_REM);
  assign w_a_neg    = w_a_signed & bus.a_i[XLEN-1];
  assign w_b_neg    = w_b_signed & bus.b_i[XLEN-1];
  assign w_a_mag    = w_a_neg ? (-bus.a_i) : bus.a_i;
  assign w_b_mag    = w_b_neg ? (-bus.b_i) : bus.b_i;

  // Remainder takes the dividend sign; everything else is the sign product.
  assign w_res_neg  = (bus.op_i == c_OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0 = w_is_div & (bus.b_i == '0);
  // op_i[0] == 0 selects the signed divide ops (DIV, REM).
  assign w_ovf  = w_is_div & ~bus.op_i[0] & (bus.a_i == c_MOST_NEG) &
                  (bus.b_i == '1);
  assign w_fast = ~w_is_div & (FAST_MUL != 0);
  assign w_short = w_div0 | w_ovf | w_fast;

  generate
    if (FAST_MUL != 0) begin : g_fast_mul
      logic [2*XLEN-1:0] w_fa;
      logic [2*XLEN-1:0] w_fb;
      assign w_fa        = {{XLEN{w_a_neg}}, bus.a_i};
      assign w_fb        = {{XLEN{w_b_neg}}, bus.b_i};
      assign w_fast_prod = w_fa * w_fb;
    end else begin : g_iter_mul
      assign w_fast_prod = '0;
    end
  endgenerate

  // op_i[1] distinguishes remainder (REM/REMU) from quotient (DIV/DIVU).
  always_comb begin
    w_short_res = '0;
    if (w_div0) begin
      w_short_res = bus.op_i[1] ? bus.a_i : '1;
    end else if (w_ovf) begin
      w_short_res = bus.op_i[1] ? '0 : bus.a_i;
    end else if (bus.op_i == c_OP_MUL) begin
      w_short_res = w_fast_prod[XLEN-1:0];
    end else begin
      w_short_res = w_fast_prod[2*XLEN-1:XLEN];
    end
  end

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  // Multiply: add multiplicand into the high half when the multiplier LSB is
  // set, then shift the {carry, hi, lo} product right by one.
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_mul_hi_nxt;
  logic [XLEN-1:0] w_mul_lo_nxt;

  assign w_sum        = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};
  assign w_mul_hi_nxt = w_sum[XLEN:1];
  assign w_mul_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};

  // Divide: restoring step. The partial remainder is always below the
  // divisor, so a modular XLEN-bit subtract yields the exact difference.
  logic [XLEN:0]   w_rs;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_div_hi_nxt;
  logic [XLEN-1:0] w_div_lo_nxt;

  assign w_rs         = {r_hi, r_lo[XLEN-1]};
  assign w_ge         = (w_rs >= {1'b0, r_b});
  assign w_sub        = w_rs[XLEN-1:0] - r_b;
  assign w_div_hi_nxt = w_ge ? w_sub : w_rs[XLEN-1:0];
  assign w_div_lo_nxt = {r_lo[XLEN-2:0], w_ge};

  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_div_sel;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_calc_res;

  assign w_hi_nxt   = r_op[2] ? w_div_hi_nxt : w_mul_hi_nxt;
  assign w_lo_nxt   = r_op[2] ? w_div_lo_nxt : w_mul_lo_nxt;

  // Result as it will stand after the final iteration, sign-corrected.
  assign w_prod     = {w_hi_nxt, w_lo_nxt};
  assign w_prod_fix = r_neg ? (-w_prod) : w_prod;
  assign w_mul_res  = (r_op == c_OP_MUL) ? w_prod_fix[XLEN-1:0]
                                         : w_prod_fix[2*XLEN-1:XLEN];
  assign w_div_sel  = r_op[1] ? w_hi_nxt : w_lo_nxt;
  assign w_div_res  = r_neg ? (-w_div_sel) : w_div_sel;
  assign w_calc_res = r_op[2] ? w_div_res : w_mul_res;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid_i) begin
            w_state_nxt = w_short ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.hold_i) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= bus.op_i;
            r_neg <= w_res_neg;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= w_a_mag;
            r_b   <= w_b_mag;
            if (w_short) begin
              r_result <= w_short_res;
            end
          end
        end
        S_CALC: begin
          if (!bus.flush_i) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + c_CNT_ONE;
            if (r_cnt == c_CNT_LAST) begin
              r_result <= w_calc_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = ((r_state == S_IDLE) & w_accept) | (r_state == S_CALC);
  assign bus.valid_o  = (r_state == S_DONE);
  assign bus.result_o = r_result;

endmodule
`default_nettype wire

// File: doc/exec_muldiv.md
Name: exec_muldiv

Overview:
Parametrised multi-cycle execute-stage unit for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), fed by the execute stage in parallel with the single-cycle ALU. It accepts one operation at a time and asserts a stall request while iterating. It returns a registered result that the execute stage muxes into its ALU-result slot of the exec state. Width and multiplier implementation are parametrised.

Parameters:
XLEN, 32, operand/result width (power of two, >= 8)
FAST_MUL, 0, 0 = iterative shift-add multiply; 1 = single-cycle array multiply (registered)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset; asynchronous, active-low
valid_i  input  1  operation request; operands and op stable while busy_o high
op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a_i  input  XLEN  rs1 operand
b_i  input  XLEN  rs2 operand
flush_i  input  1  pipeline flush (branch redirect / squash)
hold_i  input  1  downstream stall; freezes DONE state
busy_o  output  1  stall request to pipeline control
valid_o  output  1  result valid
result_o  output  XLEN  result

Behaviour:
- Reset (rst_ni low, async): state IDLE, counter 0, valid_o 0, result_o 0, all internal accumulators 0. busy_o follows its combinational equation (0 in IDLE with valid_i low).
- States IDLE, CALC, DONE. Counter width $clog2(XLEN).
- IDLE: accept when valid_i & ~flush_i. Latch op, operand magnitudes (signed per op), and result sign.
  - Go to DONE directly if any shortcut applies: divisor zero, signed overflow (DIV/REM with a_i = most-negative, b_i = -1), or FAST_MUL=1 with a multiply op.
  - Otherwise go to CALC with counter 0.
- CALC: one radix-2 iteration per cycle.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter increments each cycle. At counter == XLEN-1: apply sign correction, register result_o, go to DONE.
- DONE: valid_o = 1, result_o stable. If ~hold_i, go to IDLE next cycle (valid_o drops). If hold_i, remain in DONE.
- busy_o = (IDLE & valid_i & ~flush_i) | CALC. It is 0 in DONE, so the stage may advance as soon as the result is valid.
- Latency (accept edge = cycle 0): iterative ops give valid_o from cycle XLEN+1; shortcut ops give valid_o from cycle 1. No back-to-back acceptance; a new op is accepted no earlier than the cycle after leaving DONE.
- Results:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits, with signed×signed, signed×unsigned, and unsigned×unsigned respectively.
  - DIV/REM: truncate toward zero; remainder sign = dividend sign.
- Corner cases (RISC-V defined):
  - Divide by zero: quotient all-ones (DIV and DIVU); remainder = a_i.
  - Signed overflow: quotient = a_i; remainder 0.
- flush_i: in any state, next state is IDLE, valid_o 0 next cycle, and no result is produced. A flush in IDLE blocks acceptance that cycle. flush_i has priority over valid_i and hold_i.
- Operands are sampled only at acceptance; later changes to a_i/b_i/op_i do not affect an in-flight op.
- Async reset mid-CALC aborts immediately. After release, the first rising edge with valid_i starts a fresh op.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (-3), FAST_MUL=0 -> busy_o high cycles 0..32; valid_o at cycle 33 with result_o=0xFFFFFFEB; IDLE at cycle 34 with hold_i=0.
2. MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each valid at cycle 33.
4. DIVU a=0x1234, b=0 -> 0xFFFFFFFF at cycle 1. REM a=0x1234, b=0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1. REM same operands -> 0.
5. Flush at cycle 10 of a DIV -> busy_o low at cycle 11; valid_o never asserts; MUL issued at cycle 11 completes correctly at cycle 44.
6. hold_i high for 5 cycles in DONE -> valid_o/result_o stable throughout; IDLE the cycle after hold_i falls. rst_ni pulse mid-CALC -> outputs 0 immediately, no result after release.
